// File: rtl/m68k_bus_target_if.sv
// Backend request port of the 68000 bus responder.
// Handshake: the requester raises req_valid with req_addr/req_we/req_be/req_wdata
// stable and keeps them frozen until the backend returns req_ack=1 for one cycle
// (req_rdata valid with it). req_ack is only looked at while req_valid=1. The
// requester may withdraw req_valid without an ack (timeout or reset); the
// backend must tolerate that.
//   req_valid  requester -> backend  request pending
//   req_addr   requester -> backend  24-bit byte address, bit0 = 0
//   req_we     requester -> backend  1 = write
//   req_be     requester -> backend  {upper, lower} byte enables
//   req_wdata  requester -> backend  write data
//   req_ack    backend -> requester  request done
//   req_rdata  backend -> requester  read data, valid with req_ack
interface m68k_bus_target_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_we;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        req_ack;
  logic [15:0] req_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ack, req_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ack, req_rdata
  );
endinterface

// File: rtl/m68k_bus_target.sv
// 68000 bus responder. Decodes bus cycles driven by another master that hit an
// address window, forwards each one as a single word request on the backend
// port and terminates the bus cycle with nDTACK, or nBERR if the backend does
// not answer in time.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   nAS, nUDS, nLDS    asynchronous bus strobes (active low)
//   RnW                asynchronous read/not-write
//   A_IN, D_IN         bus address A[23:1] and data, sampled only in DECODE
//   D_OUT, D_OE        read data to the bus and its output enable
//   nDTACK_OE          1 = pull nDTACK low
//   nBERR_OE           1 = pull nBERR low
//   req                backend request port (master side)
//   state_dbg          current FSM state
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR  = 24'hE90000,
  parameter logic [23:0] ADDR_MASK  = 24'hFF0000,
  parameter int          DTACK_WAIT = 2,
  parameter int          TIMEOUT    = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                nAS,
  input  logic                nUDS,
  input  logic                nLDS,
  input  logic                RnW,
  input  logic [22:0]         A_IN,
  input  logic [15:0]         D_IN,
  output logic [15:0]         D_OUT,
  output logic                D_OE,
  output logic                nDTACK_OE,
  output logic                nBERR_OE,
  m68k_bus_target_if.master   req,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_REQ, S_WAIT, S_DTACK, S_BERR, S_IGNORE
  } state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(DTACK_WAIT);

  state_t      state, state_nxt;
  logic [1:0]  as_sync, uds_sync, lds_sync, rnw_sync;
  logic        as_s, uds_s, lds_s, rnw_s;
  logic        armed;     // nAS has been seen high while idle
  logic        aborted;   // nAS rose while the request was outstanding
  logic [7:0]  tmo;
  logic [3:0]  wait_cnt;
  logic [23:0] addr_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic [15:0] dout_q;
  logic        hit, start;

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];
  assign rnw_s = rnw_sync[1];

  assign hit   = (({A_IN, 1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign start = armed & ~as_s & (~uds_s | ~lds_s);

  // The AS synchroniser resets to "asserted" so that a strobe still held low
  // across reset cannot look like a fresh cycle: the bus must be seen idle first.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      as_sync  <= 2'b00;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
      rnw_sync <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], nAS};
      uds_sync <= {uds_sync[0], nUDS};
      lds_sync <= {lds_sync[0], nLDS};
      rnw_sync <= {rnw_sync[0], RnW};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      aborted  <= 1'b0;
      tmo      <= '0;
      wait_cnt <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
    end else begin
      state <= state_nxt;
      armed <= (state == S_IDLE) & (armed | as_s) & ~start;
      if (state == S_DECODE && hit) begin
        addr_q  <= {A_IN, 1'b0};
        we_q    <= ~rnw_s;
        be_q    <= {~uds_s, ~lds_s};
        tmo     <= '0;
        aborted <= 1'b0;
        if (!rnw_s) wdata_q <= D_IN;
      end
      if (state == S_REQ) begin
        tmo <= tmo + 8'd1;
        if (as_s) aborted <= 1'b1;
        if (req.req_ack) begin
          dout_q   <= req.req_rdata;
          wait_cnt <= WAIT_LOAD;
        end
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: state_nxt = hit ? S_REQ : S_IGNORE;
      S_REQ: begin
        // Ack wins over a timeout in the same cycle; an aborted cycle still
        // waits for the backend but is then dropped silently.
        if (req.req_ack) begin
          if (aborted || as_s)       state_nxt = S_IDLE;
          else if (WAIT_LOAD == 4'd0) state_nxt = S_DTACK;
          else                        state_nxt = S_WAIT;
        end else if (tmo == TMO_LAST) begin
          state_nxt = (aborted || as_s) ? S_IDLE : S_BERR;
        end
      end
      S_WAIT: begin
        if (as_s)                  state_nxt = S_IDLE;
        else if (wait_cnt <= 4'd1) state_nxt = S_DTACK;
      end
      S_DTACK:  if (as_s) state_nxt = S_IDLE;
      S_BERR:   if (as_s) state_nxt = S_IDLE;
      S_IGNORE: if (as_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign req.req_valid = (state == S_REQ);
  assign req.req_addr  = addr_q;
  assign req.req_we    = we_q;
  assign req.req_be    = be_q;
  assign req.req_wdata = wdata_q;

  assign D_OUT     = dout_q;
  assign D_OE      = ((state == S_WAIT) || (state == S_DTACK)) && !we_q;
  assign nDTACK_OE = (state == S_DTACK);
  assign nBERR_OE  = (state == S_BERR);
  assign state_dbg = state;

endmodule
